// File: rtl/pimc_pkg.sv
// pimc_pkg: shared types and constants for the pimc_ng interrupt controller.
//   irq_entry_t  - one irqtab entry {mask, edge_trig, prio, cpuid}, MSB first,
//                  laid out exactly like the cfg_wdata word.
//   pimc_state_t - notification FSM states.
//   Field widths live here because the entry struct is shared by every file.
//   A different prio/cpuid width is obtained by editing these localparams.
//   The top-level PRIO_WIDTH/CPUID_WIDTH parameters must stay equal to them.
package pimc_pkg;

    localparam int PIMC_FLAG_W  = 32'sd2;   // mask + edge_trig
    localparam int PIMC_PRIO_W  = 32'sd3;
    localparam int PIMC_CPUID_W = 32'sd8;
    localparam int PIMC_LINE_W  = 32'sd8;   // width of the lineno output
    localparam int PIMC_CFG_W   = PIMC_FLAG_W + PIMC_PRIO_W + PIMC_CPUID_W;
    localparam int PIMC_PINS_DEF = 32'sd16;

    typedef struct packed {
        logic                    mask;       // 1 = excluded from arbitration
        logic                    edge_trig;  // 1 = edge-triggered, 0 = level
        logic [PIMC_PRIO_W-1:0]  prio;
        logic [PIMC_CPUID_W-1:0] cpuid;
    } irq_entry_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_NOTIFY = 1'b1
    } pimc_state_t;

    // Reset value of every entry: masked, level, priority 0, cpu 0.
    localparam irq_entry_t IRQ_ENTRY_RST = '{
        mask:      1'b1,
        edge_trig: 1'b0,
        prio:      {PIMC_PRIO_W{1'b0}},
        cpuid:     {PIMC_CPUID_W{1'b0}}
    };

    // The configuration word is packed in the same order as the struct.
    function automatic irq_entry_t cfg_to_entry(input logic [PIMC_CFG_W-1:0] word);
        return irq_entry_t'(word);
    endfunction

endpackage

// File: rtl/pimc_arb.sv
// pimc_arb: combinational priority arbiter.
//   eligible [N]     - lines allowed to compete this cycle
//   prio     [N][PW] - priority of each line (larger wins)
//   valid            - at least one line is eligible
//   index    [IW]    - winning line; on equal priority the lowest index wins
module pimc_arb #(
    parameter int N  = 32'sd16,
    parameter int PW = 32'sd3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]         eligible,
    input  logic [N-1:0][PW-1:0] prio,
    output logic                 valid,
    output logic [IW-1:0]        index
);

    logic [PW-1:0] best_prio_s;

    // Ascending scan; a strictly greater priority is needed to replace the
    // current winner, which is what gives ties to the lowest index.
    always_comb begin
        valid       = 1'b0;
        index       = {IW{1'b0}};
        best_prio_s = {PW{1'b0}};
        for (int i = 32'sd0; i < N; i++) begin
            if (eligible[i] && (!valid || (prio[i] > best_prio_s))) begin
                valid       = 1'b1;
                index       = IW'(i);
                best_prio_s = prio[i];
            end else begin
                best_prio_s = best_prio_s;
            end
        end
    end

endmodule

// File: rtl/pimc_ng.sv
// pimc_ng: programmable interrupt controller, one notification at a time.
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   irq_in        - interrupt request lines, synchronous to clk
//   cfg_we        - irqtab write strobe
//   cfg_line      - irqtab entry written (indices >= IRQ_PIN_COUNT ignored)
//   cfg_wdata     - {mask, edge, prio, cpuid}
//   irqack        - processor acknowledge of the current notification
//   notify        - a notification is presented on lineno/processor_id
//   lineno        - notified line, zero-extended to 8 bits
//   processor_id  - cpuid of the notified line, captured at notification
module pimc_ng
    import pimc_pkg::*;
#(
    parameter  int IRQ_PIN_COUNT = PIMC_PINS_DEF,
    parameter  int PRIO_WIDTH    = PIMC_PRIO_W,
    parameter  int CPUID_WIDTH   = PIMC_CPUID_W,
    localparam int LINE_IDX_W    = $clog2(IRQ_PIN_COUNT),
    localparam int CFG_W         = PIMC_FLAG_W + PRIO_WIDTH + CPUID_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IRQ_PIN_COUNT-1:0] irq_in,
    input  logic                     cfg_we,
    input  logic [LINE_IDX_W-1:0]    cfg_line,
    input  logic [CFG_W-1:0]         cfg_wdata,
    input  logic                     irqack,
    output logic                     notify,
    output logic [PIMC_LINE_W-1:0]   lineno,
    output logic [CPUID_WIDTH-1:0]   processor_id
);

    irq_entry_t                             irqtab_r [IRQ_PIN_COUNT];
    logic [IRQ_PIN_COUNT-1:0]               irq_q_r;
    logic [IRQ_PIN_COUNT-1:0]               pending_r;
    logic [IRQ_PIN_COUNT-1:0]               pending_nxt_s;
    logic [IRQ_PIN_COUNT-1:0]               mask_s;
    logic [IRQ_PIN_COUNT-1:0]               edge_s;
    logic [IRQ_PIN_COUNT-1:0]               notified_s;
    logic [IRQ_PIN_COUNT-1:0]               eligible_s;
    logic [IRQ_PIN_COUNT-1:0][PRIO_WIDTH-1:0] prio_s;

    pimc_state_t                 state_r;
    pimc_state_t                 state_nxt_s;
    logic                        load_s;
    logic                        ack_s;
    logic                        cfg_hit_s;
    logic                        arb_valid_s;
    logic [LINE_IDX_W-1:0]       arb_idx_s;

    logic                        notify_r;
    logic [PIMC_LINE_W-1:0]      lineno_r;
    logic [CPUID_WIDTH-1:0]      cpuid_r;

    // Writes addressing a line beyond the table are dropped.
    always_comb begin
        cfg_hit_s = cfg_we && (int'(cfg_line) < IRQ_PIN_COUNT);
    end

    // irqtab storage; reset leaves every line masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 32'sd0; i < IRQ_PIN_COUNT; i++) begin
                irqtab_r[i] <= IRQ_ENTRY_RST;
            end
        end else if (cfg_hit_s) begin
            irqtab_r[cfg_line] <= cfg_to_entry(cfg_wdata);
        end else begin
            irqtab_r <= irqtab_r;
        end
    end

    // Flatten the table into per-line vectors and flag the notified line.
    always_comb begin
        mask_s     = {IRQ_PIN_COUNT{1'b0}};
        edge_s     = {IRQ_PIN_COUNT{1'b0}};
        notified_s = {IRQ_PIN_COUNT{1'b0}};
        prio_s     = {(IRQ_PIN_COUNT*PRIO_WIDTH){1'b0}};
        for (int i = 32'sd0; i < IRQ_PIN_COUNT; i++) begin
            mask_s[i]     = irqtab_r[i].mask;
            edge_s[i]     = irqtab_r[i].edge_trig;
            prio_s[i]     = irqtab_r[i].prio;
            notified_s[i] = (state_r == ST_NOTIFY) && (lineno_r == PIMC_LINE_W'(i));
        end
    end

    // Next pending vector. A new request always wins over the ack clear, so an
    // edge arriving together with irqack is kept. A level line follows its pin,
    // except that the line being notified keeps pending until it is acked.
    always_comb begin
        pending_nxt_s = {IRQ_PIN_COUNT{1'b0}};
        for (int i = 32'sd0; i < IRQ_PIN_COUNT; i++) begin
            if (edge_s[i]) begin
                pending_nxt_s[i] = (irq_in[i] & ~irq_q_r[i])
                                 | (pending_r[i] & ~(ack_s & notified_s[i]));
            end else begin
                pending_nxt_s[i] = irq_in[i] | (pending_r[i] & notified_s[i] & ~ack_s);
            end
        end
    end

    // Input sampling register and pending latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q_r   <= {IRQ_PIN_COUNT{1'b0}};
            pending_r <= {IRQ_PIN_COUNT{1'b0}};
        end else begin
            irq_q_r   <= irq_in;
            pending_r <= pending_nxt_s;
        end
    end

    // Masked lines keep pending but do not compete.
    always_comb begin
        eligible_s = pending_r & ~mask_s;
    end

    pimc_arb #(
        .N  (IRQ_PIN_COUNT),
        .PW (PRIO_WIDTH),
        .IW (LINE_IDX_W)
    ) u_arb (
        .eligible (eligible_s),
        .prio     (prio_s),
        .valid    (arb_valid_s),
        .index    (arb_idx_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state. irqack is only meaningful in NOTIFY, and arbitration only
    // runs in IDLE, so a later higher-priority request cannot preempt.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        ack_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_nxt_s = ST_NOTIFY;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_NOTIFY: begin
                if (irqack) begin
                    state_nxt_s = ST_IDLE;
                    ack_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_NOTIFY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Notification outputs are captured once from the winner and held, so a
    // table rewrite during NOTIFY cannot change what the processor sees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            notify_r <= 1'b0;
            lineno_r <= {PIMC_LINE_W{1'b0}};
            cpuid_r  <= {CPUID_WIDTH{1'b0}};
        end else if (load_s) begin
            notify_r <= 1'b1;
            lineno_r <= PIMC_LINE_W'(arb_idx_s);
            cpuid_r  <= irqtab_r[arb_idx_s].cpuid;
        end else if (ack_s) begin
            notify_r <= 1'b0;
        end else begin
            notify_r <= notify_r;
        end
    end

    assign notify       = notify_r;
    assign lineno       = lineno_r;
    assign processor_id = cpuid_r;

endmodule

// File: tb/tb_pimc_ng.sv
// tb_pimc_ng: self-checking bench for pimc_ng (12 lines, so that table
// indices beyond the last line can be driven on the 4-bit cfg_line port).
`timescale 1ns/1ps
module tb_pimc_ng;

    localparam int N  = 12;
    localparam int PW = 3;
    localparam int CW = 8;
    localparam int LW = $clog2(N);
    localparam int DW = 2 + PW + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in;
    logic          cfg_we;
    logic [LW-1:0] cfg_line;
    logic [DW-1:0] cfg_wdata;
    logic          irqack;
    logic          notify;
    logic [7:0]    lineno;
    logic [CW-1:0] processor_id;

    pimc_ng #(.IRQ_PIN_COUNT(N), .PRIO_WIDTH(PW), .CPUID_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .cfg_we       (cfg_we),
        .cfg_line     (cfg_line),
        .cfg_wdata    (cfg_wdata),
        .irqack       (irqack),
        .notify       (notify),
        .lineno       (lineno),
        .processor_id (processor_id)
    );

    // 50 MHz
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ent(input bit m, input bit e, input int p, input int c);
        logic [PW-1:0] pv;
        logic [CW-1:0] cv;
        pv = PW'(p);
        cv = CW'(c);
        return {m, e, pv, cv};
    endfunction

    // ---------------- reference model (one transaction at a time) ----------
    bit m_pend [N];
    bit m_prev [N];
    bit m_mask [N];
    bit m_edge [N];
    int m_prio [N];
    int m_cpu  [N];
    bit m_busy;
    int m_line;
    int m_pid;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_prev[i] = 0; m_mask[i] = 1;
            m_edge[i] = 0; m_prio[i] = 0; m_cpu[i]  = 0;
        end
        m_busy = 0; m_line = 0; m_pid = 0;
    endtask

    // Highest score = highest priority, then lowest index.
    function automatic int model_winner();
        int best = -1;
        int best_score = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && !m_mask[i] && (m_prio[i] * N + (N - 1 - i)) > best_score) begin
                best_score = m_prio[i] * N + (N - 1 - i);
                best = i;
            end
        end
        return best;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int w;
        bit ack;
        bit np [N];
        int l;
        w   = m_busy ? -1 : model_winner();
        ack = m_busy && irqack;
        for (int i = 0; i < N; i++) begin
            if (m_edge[i])
                np[i] = (irq_in[i] && !m_prev[i]) || (m_pend[i] && !(ack && i == m_line));
            else
                np[i] = irq_in[i] || (m_pend[i] && m_busy && !ack && i == m_line);
        end
        if (w >= 0) begin
            m_busy = 1; m_line = w; m_pid = m_cpu[w];
        end else if (ack) begin
            m_busy = 0;
        end
        l = int'(cfg_line);
        if (cfg_we && l < N) begin
            m_mask[l] = cfg_wdata[DW-1];
            m_edge[l] = cfg_wdata[DW-2];
            m_prio[l] = int'(cfg_wdata[CW +: PW]);
            m_cpu[l]  = int'(cfg_wdata[CW-1:0]);
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = irq_in[i];
        end
    endtask

    // One clock: step the model, take the edge, compare away from the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model notify", notify, m_busy);
        if (m_busy) begin
            check("model lineno", lineno, m_line);
            check("model processor_id", processor_id, m_pid);
        end
    endtask

    task automatic drive(input logic [N-1:0] irq, input bit we, input int line,
                         input logic [DW-1:0] wd, input bit ack);
        irq_in = irq; cfg_we = we; cfg_line = LW'(line); cfg_wdata = wd; irqack = ack;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic [N-1:0]  irq;
        bit            we;
        int            line;
        logic [DW-1:0] wd;
        bit            ack;
        bit            en;
        int            el;
        int            ep;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [N-1:0] irq, input bit we, input int line,
                                input logic [DW-1:0] wd, input bit ack,
                                input bit en, input int el, input int ep);
        vec_t v;
        v.irq = irq; v.we = we; v.line = line; v.wd = wd; v.ack = ack;
        v.en = en; v.el = el; v.ep = ep;
        vecs.push_back(v);
    endfunction

    localparam logic [DW-1:0] Z = '0;

    initial begin
        model_reset();
        rst = 1'b1;
        drive('0, 0, 0, Z, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset notify", notify, 0);
        check("reset lineno", lineno, 0);
        check("reset processor_id", processor_id, 0);
        rst = 1'b0;

        // Line 5: edge, prio 2, cpu 0x03; ack in idle ignored; rewrite during notify.
        add(12'h000, 1, 5, ent(0,1,2,8'h03), 0, 0,0,0);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h020, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 1, 1,5,8'h03);
        add(12'h000, 0, 0, Z, 0, 1,5,8'h03);
        add(12'h000, 1, 5, ent(0,1,7,8'hEE), 0, 1,5,8'h03);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 1, 5, ent(0,1,2,8'h03), 0, 0,0,0);
        // Out-of-range table write.
        add(12'h000, 1, 13, ent(0,1,7,8'h55), 0, 0,0,0);
        // Lines 2 (prio 1) and 9 (prio 4) together.
        add(12'h000, 1, 2, ent(0,1,1,8'h22), 0, 0,0,0);
        add(12'h000, 1, 9, ent(0,1,4,8'h99), 0, 0,0,0);
        add(12'h204, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 1,9,8'h99);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 1,2,8'h22);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        // Lines 3 and 7, equal prio 4.
        add(12'h000, 1, 3, ent(0,1,4,8'h33), 0, 0,0,0);
        add(12'h000, 1, 7, ent(0,1,4,8'h77), 0, 0,0,0);
        add(12'h088, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 1,3,8'h33);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 1,7,8'h77);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        // Line 4 masked, pulsed, then unmasked.
        add(12'h000, 1, 4, ent(1,1,5,8'h44), 0, 0,0,0);
        add(12'h010, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 1, 4, ent(0,1,5,8'h44), 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 1,4,8'h44);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        // Line 1 level.
        add(12'h000, 1, 1, ent(0,0,3,8'h11), 0, 0,0,0);
        add(12'h002, 0, 0, Z, 0, 0,0,0);
        add(12'h002, 0, 0, Z, 0, 1,1,8'h11);
        add(12'h002, 0, 0, Z, 1, 0,0,0);
        add(12'h002, 0, 0, Z, 0, 1,1,8'h11);
        add(12'h000, 0, 0, Z, 0, 1,1,8'h11);
        add(12'h000, 0, 0, Z, 1, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);
        add(12'h000, 0, 0, Z, 0, 0,0,0);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].irq, vecs[k].we, vecs[k].line, vecs[k].wd, vecs[k].ack);
            tick();
            check($sformatf("vec%0d notify", k), notify, vecs[k].en);
            if (vecs[k].en) begin
                check($sformatf("vec%0d lineno", k), lineno, vecs[k].el);
                check($sformatf("vec%0d processor_id", k), processor_id, vecs[k].ep);
            end
        end

        // New edge on line 5 in the same cycle as its ack is not lost.
        drive(12'h020, 0, 0, Z, 0); tick();
        drive(12'h000, 0, 0, Z, 0); tick();
        check("edge+ack setup notify", notify, 1);
        check("edge+ack setup lineno", lineno, 5);
        drive(12'h020, 0, 0, Z, 1); tick();
        check("edge+ack notify drop", notify, 0);
        drive(12'h000, 0, 0, Z, 0); tick();
        check("edge+ack renotify", notify, 1);
        check("edge+ack renotify lineno", lineno, 5);
        drive(12'h000, 0, 0, Z, 1); tick();
        drive(12'h000, 0, 0, Z, 0); tick();
        check("edge+ack final idle", notify, 0);

        // Reset during NOTIFY with lines 0 and 6 pending.
        drive(12'h000, 1, 0, ent(0,1,1,8'h0A), 0); tick();
        drive(12'h000, 1, 6, ent(0,1,2,8'h6B), 0); tick();
        drive(12'h041, 0, 0, Z, 0); tick();
        drive(12'h000, 0, 0, Z, 0); tick();
        check("pre-reset notify", notify, 1);
        check("pre-reset lineno", lineno, 6);
        #4;
        rst = 1'b1;
        #1;
        check("async reset notify", notify, 0);
        check("async reset lineno", lineno, 0);
        check("async reset processor_id", processor_id, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(12'h000, 1, 0, ent(0,1,1,8'h0A), 0); tick();
        drive(12'h000, 1, 6, ent(0,1,2,8'h6B), 0); tick();
        drive(12'h000, 0, 0, Z, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post-reset quiet", notify, 0);
        end
        drive(12'h001, 0, 0, Z, 0); tick();
        drive(12'h000, 0, 0, Z, 0); tick();
        check("post-reset new edge notify", notify, 1);
        check("post-reset new edge lineno", lineno, 0);
        drive(12'h000, 0, 0, Z, 1); tick();

        // Randomised run against the model.
        for (int i = 0; i < N; i++) begin
            drive('0, 1, i, ent($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                                $urandom_range(0, 7), $urandom_range(0, 255)), 0);
            tick();
        end
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] r;
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 5) == 0);
            drive(r, $urandom_range(0, 19) == 0, $urandom_range(0, 15),
                  ent($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                      $urandom_range(0, 7), $urandom_range(0, 255)),
                  $urandom_range(0, 2) == 0);
            tick();
        end
        drive('0, 0, 0, Z, 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pimc_ng.md
PIMC_NG -- requirements
Module: pimc_ng

Interface
REQ-001 The block SHALL have parameter IRQ_PIN_COUNT, default 16, number of interrupt lines (2..256).
REQ-002 The block SHALL have parameter PRIO_WIDTH, default 3, width of the per-line priority field.
REQ-003 The block SHALL have parameter CPUID_WIDTH, default 8, width of the target processor id.
REQ-004 The block SHALL have port clk, input, 1, the single clock (50 MHz); all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port irq_in, input, IRQ_PIN_COUNT, synchronous interrupt request lines.
REQ-007 The block SHALL have port cfg_we, input, 1, irqtab write strobe.
REQ-008 The block SHALL have port cfg_line, input, $clog2(IRQ_PIN_COUNT), irqtab entry index.
REQ-009 The block SHALL have port cfg_wdata, input, 2+PRIO_WIDTH+CPUID_WIDTH, packed as {mask, edge, prio, cpuid}, MSB first.
REQ-010 The block SHALL have port irqack, input, 1, processor acknowledge of the current notification.
REQ-011 The block SHALL have port notify, output, 1, active-high; a message is valid on lineno/processor_id.
REQ-012 The block SHALL have port lineno, output, 8, index of the notified line.
REQ-013 The block SHALL have port processor_id, output, CPUID_WIDTH, target cpuid of the notified line.

Function
REQ-014 irqtab SHALL hold one entry per line: mask, edge (1 = edge-triggered, 0 = level), prio, cpuid; cfg_we=1 writes cfg_wdata to entry cfg_line at the clock edge.
REQ-015 cfg_we with cfg_line >= IRQ_PIN_COUNT SHALL be ignored.
REQ-016 irq_in SHALL be registered once (irq_q); an edge line SHALL set pending[i] when irq_in[i]=1 and irq_q[i]=0.
REQ-017 A level line SHALL set pending[i] while irq_in[i]=1 and SHALL NOT hold pending once irq_in[i]=0 outside a notification.
REQ-018 Masked lines SHALL still latch pending but SHALL be excluded from arbitration; unmasking SHALL make a retained pending line eligible on the next cycle.
REQ-019 Arbitration SHALL select the eligible line with the highest prio; ties SHALL go to the lowest index.
REQ-020 FSM states SHALL be IDLE and NOTIFY; reset state is IDLE.
REQ-021 In IDLE with at least one eligible line, the FSM SHALL go to NOTIFY and, on that same edge, register lineno and processor_id from the winner and set notify=1.
REQ-022 Latency SHALL be exactly 2 clocks from an irq_in rising edge to notify=1 when idle, unmasked and highest priority.
REQ-023 In NOTIFY, notify, lineno and processor_id SHALL hold stable until irqack=1.
REQ-024 irqack=1 in NOTIFY SHALL clear pending[lineno], deassert notify and return to IDLE on that edge; the next notification appears no earlier than the following edge.
REQ-025 A level line still high after ack SHALL re-pend and may be re-notified.
REQ-026 irqack in IDLE SHALL be ignored.
REQ-027 A new edge on the acknowledged line in the same cycle as irqack SHALL leave pending set; the event is not lost.
REQ-028 An irqtab write to the line currently notified SHALL NOT alter the outputs of the current notification.
REQ-029 A higher-priority arrival during NOTIFY SHALL NOT preempt; it is arbitrated after ack.
REQ-030 lineno SHALL be zero-extended to 8 bits.

Reset
REQ-031 On rst: state=IDLE, notify=0, lineno=0, processor_id=0, pending=0, irq_q=0, all irqtab entries {mask=1, edge=0, prio=0, cpuid=0}.
REQ-032 rst asserted mid-NOTIFY SHALL drop notify immediately (asynchronously) and discard all pending.

Structure
REQ-033 Package pimc_pkg SHALL hold the irqtab entry struct, FSM state enum, and field-width localparams.
REQ-034 Arbitration SHALL be a combinational sub-module pimc_arb (inputs: eligible vector, prio array; outputs: valid, index).

Verification
REQ-035 Line 5 unmasked, edge, prio 2, cpuid 0x03; pulse irq_in[5] at cycle 10 -> notify=1 at cycle 12, lineno=5, processor_id=0x03.
REQ-036 Lines 2 (prio 1) and 9 (prio 4) rise together -> line 9 notified first; after ack, line 2 notified.
REQ-037 Lines 3 and 7 both prio 4 -> line 3 first; line 7 second.
REQ-038 Line 4 masked, pulsed, then unmasked -> no notify while masked; notify lineno=4 two cycles after the unmask write.
REQ-039 Line 1 level held high; ack -> notify re-asserts for lineno=1; drop irq_in[1] then ack -> notify stays 0.
REQ-040 rst asserted while notify=1 with lines 0 and 6 pending -> notify=0 immediately; after release, no notify until a new edge.
